uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
Boot-time program loader that sits directly upstream of the single-cycle RV32I processor's byte-wide program-load port. Receives a length-prefixed binary image over a UART 8N1 line and emits one memory-write strobe per image byte (enable, data, address). Holds the processor in reset while loading and releases it once the image is complete. Latches any framing error or oversize image and keeps the processor held in reset.

Parameters:
WIDTH, 32, width of mem_data and mem_addr; matches processor WIDTH
MEM_DEPTH, 2048, processor memory size in bytes; the largest legal image length
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be at least 4
LEN_BYTES, 4, number of little-endian length-header bytes

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high
rx  input  1  asynchronous UART receive line; idle high
mem_en  output  1  single-cycle write strobe to the processor's memEn
mem_data  output  WIDTH  {zeros, byte}; drives processor memData
mem_addr  output  WIDTH  byte address; drives processor memAddr
cpu_reset  output  1  high holds the processor in reset
busy  output  1  a load is in progress
done  output  1  image complete; sticky until reset
err  output  1  framing error or length > MEM_DEPTH; sticky until reset

Behaviour:
- Reset values: mem_en=0, mem_data=0, mem_addr=0, cpu_reset=1, busy=0, done=0, err=0. All internal counters are 0; the FSM enters LEN.
- Reset mid-load aborts the load. The next image restarts at address 0.
- rx passes through a 2-flop synchroniser, which adds 2 cycles of latency. All sampling uses the synchronised signal.
- UART receiver states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised rx of 0 moves to START with the bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. If rx=1 it is a glitch: return to IDLE with no output. If rx=0, move to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, shifted into the byte register.
  - STOP: sample once after CLKS_PER_BIT cycles. rx=1 gives a 1-cycle byte_valid pulse with the byte. rx=0 gives a 1-cycle frame_err pulse. Either way, return to IDLE.
  - A new start bit is accepted from the cycle after STOP.
- Loader FSM states: LEN, DATA, DONE, ERR.
  - LEN: collect LEN_BYTES bytes, little-endian, into len (WIDTH bits). busy rises on the first byte_valid in LEN.
  - After the last header byte:
    - len=0: go to DONE.
    - len>MEM_DEPTH: go to ERR.
    - otherwise: go to DATA with idx=0.
  - DATA: each byte_valid causes, on the next cycle:
    - mem_en=1 for exactly one cycle;
    - mem_data={(WIDTH-8)'0, byte};
    - mem_addr=idx.
    - idx then increments.
  - mem_addr and mem_data hold their values between strobes.
  - When the strobe for idx=len-1 is issued, go to DONE on the following cycle.
  - DONE: done=1, busy=0, cpu_reset=0 from the cycle after the final mem_en. Further rx traffic is ignored.
  - ERR: err=1, busy=0, cpu_reset stays 1, mem_en is never asserted. Only reset leaves ERR.
  - A frame_err in LEN or DATA goes to ERR. A frame_err in DONE is ignored.
- Relation between strobes and reset:
  - mem_en is never high while cpu_reset=0.
  - cpu_reset stays high on the cycle carrying the final strobe. It deasserts no earlier than 1 cycle after the final strobe.
- Widths:
  - idx and len are WIDTH bits wide.
  - The comparison with MEM_DEPTH is unsigned.
  - idx never exceeds len-1, so mem_addr never wraps.

Decomposition:
- Package loader_pkg:
  - typedef enum uart_state_t {IDLE, START, DATA, STOP};
  - typedef enum load_state_t {LEN, DATA, DONE, ERR};
  - localparam BYTE_W=8.
- Sub-module uart_rx contains the synchroniser, the bit timer, the receiver FSM, and the byte_valid/frame_err outputs.
- uart_prog_loader instantiates uart_rx and contains the loader FSM plus the output registers.

Test Plan:
- Header 04 00 00 00, then bytes 13 00 00 00 (a NOP), with CLKS_PER_BIT=4 -> four mem_en pulses at addr 0..3, data 0x13,0x00,0x00,0x00; done=1 and cpu_reset=0 one cycle after the 4th pulse; busy=0.
- Header 00 00 00 00 -> no mem_en; done=1 and cpu_reset=0 the cycle after the 4th header byte_valid.
- Header 01 08 00 00 (len 2049) -> err=1, cpu_reset stays 1, no mem_en; further bytes are ignored.
- Stop bit forced 0 on the 2nd data byte of a 4-byte image -> exactly 1 mem_en (addr 0); err=1; cpu_reset=1.
- rx low pulse of 1 cycle (shorter than CLKS_PER_BIT/2) while idle -> no byte_valid and busy=0; the next valid image loads normally.
- Assert reset after 2 of 4 data bytes, then resend the full image -> outputs return to their reset values; reload starts at addr 0; the final state is done=1.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  localparam int BYTE_W = 8;

  // Receiver FSM states (prefixed so both enums can share this package).
  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

  // Loader FSM states.
  typedef enum logic [1:0] {
    L_LEN  = 2'd0,
    L_DATA = 2'd1,
    L_DONE = 2'd2,
    L_ERR  = 2'd3
  } load_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte-wide program-load bus towards the processor memory port.
interface uart_prog_loader_if #(
  parameter int WIDTH = 32
);
  logic             mem_en;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] mem_addr;

  modport master (output mem_en, output mem_data, output mem_addr);
  modport slave  (input  mem_en, input  mem_data, input  mem_addr);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// UART 8N1 receiver: rx synchroniser, bit timer, byte_valid/frame_err pulses.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              frame_err
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic              rx_meta_r, rx_sync_r;
  uart_state_t       state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [2:0]        bit_cnt_r, bit_cnt_s;
  logic [BYTE_W-1:0] shift_r, shift_s;
  logic              valid_r, valid_s, ferr_r, ferr_s;

  // Two-flop synchroniser for the asynchronous rx line (idles high).
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state, timer, shift register and pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= U_IDLE;
      cnt_r     <= '0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      valid_r   <= valid_s;
      ferr_r    <= ferr_s;
    end
  end

  // Receiver next-state: half-bit start check, then full-bit sampling.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    valid_s   = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      U_IDLE: begin
        if (!rx_sync_r) begin
          state_s   = U_START;
          cnt_s     = '0;
          bit_cnt_s = 3'd0;
        end else begin
          cnt_s = '0;
        end
      end
      U_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s   = '0;
          state_s = rx_sync_r ? U_IDLE : U_DATA;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      U_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_s     = '0;
          shift_s   = {rx_sync_r, shift_r[BYTE_W-1:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = U_STOP;
          end else begin
            state_s = U_DATA;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      U_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_s   = '0;
          state_s = U_IDLE;
          if (rx_sync_r) begin
            valid_s = 1'b1;
          end else begin
            ferr_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = U_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  assign byte_valid = valid_r;
  assign byte_data  = shift_r;
  assign frame_err  = ferr_r;
endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: length-prefixed UART image -> byte-wide memory write strobes.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MEM_DEPTH    = 2048,
  parameter int CLKS_PER_BIT = 868,
  parameter int LEN_BYTES    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  uart_prog_loader_if.master   mem,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int HDR_W = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam logic [HDR_W-1:0] LAST_HDR = HDR_W'(LEN_BYTES - 1);

  logic              byte_valid_s, frame_err_s;
  logic [BYTE_W-1:0] byte_data_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .frame_err  (frame_err_s)
  );

  load_state_t      state_r, state_s;
  logic [WIDTH-1:0] len_r, len_s, idx_r, idx_s;
  logic [HDR_W-1:0] hdr_cnt_r, hdr_cnt_s;
  logic             last_r, last_s, strobe_s, busy_s;
  logic             mem_en_r, cpu_reset_r, busy_r, done_r, err_r;
  logic [WIDTH-1:0] mem_data_r, mem_addr_r;

  // Loader next-state: header collection, strobe generation, terminal states.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    idx_s     = idx_r;
    hdr_cnt_s = hdr_cnt_r;
    last_s    = last_r;
    strobe_s  = 1'b0;
    case (state_r)
      L_LEN: begin
        if (frame_err_s) begin
          state_s = L_ERR;
        end else if (byte_valid_s) begin
          len_s = len_r | (WIDTH'(byte_data_s) << {hdr_cnt_r, 3'b000});
          if (hdr_cnt_r == LAST_HDR) begin
            hdr_cnt_s = '0;
            idx_s     = '0;
            if (len_s == '0) begin
              state_s = L_DONE;
            end else if (len_s > WIDTH'(MEM_DEPTH)) begin
              state_s = L_ERR;
            end else begin
              state_s = L_DATA;
            end
          end else begin
            hdr_cnt_s = hdr_cnt_r + HDR_W'(1);
          end
        end else begin
          state_s = L_LEN;
        end
      end
      L_DATA: begin
        if (frame_err_s) begin
          state_s = L_ERR;
        end else if (last_r) begin
          // Final strobe is on the bus this cycle; release next cycle.
          state_s = L_DONE;
        end else if (byte_valid_s) begin
          strobe_s = 1'b1;
          idx_s    = idx_r + WIDTH'(1);
          last_s   = (idx_r == len_r - WIDTH'(1));
        end else begin
          state_s = L_DATA;
        end
      end
      L_DONE:  state_s = L_DONE;
      L_ERR:   state_s = L_ERR;
      default: state_s = L_ERR;
    endcase
  end

  // busy covers the span from the first header byte to the final strobe.
  always_comb begin
    busy_s = 1'b0;
    if (state_s == L_DATA) begin
      busy_s = 1'b1;
    end else if (state_s == L_LEN) begin
      busy_s = (hdr_cnt_s != '0);
    end else begin
      busy_s = 1'b0;
    end
  end

  // Loader state, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= L_LEN;
      len_r       <= '0;
      idx_r       <= '0;
      hdr_cnt_r   <= '0;
      last_r      <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_data_r  <= '0;
      mem_addr_r  <= '0;
      cpu_reset_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      idx_r       <= idx_s;
      hdr_cnt_r   <= hdr_cnt_s;
      last_r      <= last_s;
      mem_en_r    <= strobe_s;
      if (strobe_s) begin
        mem_data_r <= WIDTH'(byte_data_s);
        mem_addr_r <= idx_r;
      end
      cpu_reset_r <= (state_s != L_DONE);
      busy_r      <= busy_s;
      done_r      <= (state_s == L_DONE);
      err_r       <= (state_s == L_ERR);
    end
  end

  assign mem.mem_en   = mem_en_r;
  assign mem.mem_data = mem_data_r;
  assign mem.mem_addr = mem_addr_r;
  assign cpu_reset    = cpu_reset_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with CLKS_PER_BIT=4.
module tb_uart_prog_loader;
  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic cpu_reset, busy, done, err;

  int total = 0;
  int bad   = 0;

  uart_prog_loader_if #(.WIDTH(32)) mem_bus ();

  uart_prog_loader #(
    .WIDTH(32), .MEM_DEPTH(2048), .CLKS_PER_BIT(CPB), .LEN_BYTES(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .mem       (mem_bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  // Strobe / byte_valid / done-edge recorder, sampled on the falling edge.
  int          cyc = 0;
  int          n_strobe = 0, n_bv = 0, n_viol = 0;
  int          last_strobe_cyc = 0, last_bv_cyc = 0, done_rise_cyc = 0;
  logic        prev_done = 1'b0;
  logic [31:0] st_addr [64];
  logic [31:0] st_data [64];

  always @(negedge clock) begin
    cyc <= cyc + 1;
    prev_done <= done;
    if (mem_bus.mem_en) begin
      st_addr[n_strobe % 64] <= mem_bus.mem_addr;
      st_data[n_strobe % 64] <= mem_bus.mem_data;
      n_strobe <= n_strobe + 1;
      last_strobe_cyc <= cyc;
      if (!cpu_reset) n_viol <= n_viol + 1;
    end
    if (dut.u_rx.byte_valid) begin
      n_bv <= n_bv + 1;
      last_bv_cyc <= cyc;
    end
    if (done && !prev_done) done_rise_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clock);
    rx = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic send_hdr(input logic [31:0] len);
    send_byte(len[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
    send_byte(len[23:16], 1'b1);
    send_byte(len[31:24], 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_en"},    {31'd0, mem_bus.mem_en}, 32'd0);
    check({tag, "_mem_data"},  mem_bus.mem_data, 32'd0);
    check({tag, "_mem_addr"},  mem_bus.mem_addr, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
    check({tag, "_done"},      {31'd0, done}, 32'd0);
    check({tag, "_err"},       {31'd0, err}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    rx = 1'b1;
    wait_cyc(3);
    check_reset_vals(tag);
    reset = 1'b0;
    wait_cyc(2);
  endtask

  task automatic check_strobe(input string tag, input int k, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_addr"}, st_addr[k % 64], a);
    check({tag, "_data"}, st_data[k % 64], d);
  endtask

  initial begin
    int base;

    // 1: 4-byte NOP image.
    do_reset("rst1");
    base = n_strobe;
    send_hdr(32'd4);
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    wait_cyc(10);
    check("t1_count", n_strobe - base, 32'd4);
    check_strobe("t1_s0", base + 0, 32'd0, 32'h13);
    check_strobe("t1_s1", base + 1, 32'd1, 32'h00);
    check_strobe("t1_s2", base + 2, 32'd2, 32'h00);
    check_strobe("t1_s3", base + 3, 32'd3, 32'h00);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_done_lat", done_rise_cyc - last_strobe_cyc, 32'd1);
    base = n_strobe;
    send_byte(8'h77, 1'b1);
    wait_cyc(5);
    check("t1_ignore", n_strobe - base, 32'd0);

    // 2: zero-length image.
    do_reset("rst2");
    base = n_strobe;
    send_hdr(32'd0);
    wait_cyc(5);
    check("t2_count", n_strobe - base, 32'd0);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("t2_done_lat", done_rise_cyc - last_bv_cyc, 32'd1);

    // 3: oversize length 2049.
    do_reset("rst3");
    base = n_strobe;
    send_hdr(32'd2049);
    wait_cyc(3);
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    wait_cyc(5);
    check("t3_count", n_strobe - base, 32'd0);
    check("t3_err_hold", {31'd0, err}, 32'd1);
    check("t3_done", {31'd0, done}, 32'd0);

    // 3b: length exactly MEM_DEPTH is legal.
    do_reset("rst3b");
    send_hdr(32'd2048);
    wait_cyc(3);
    check("t3b_err", {31'd0, err}, 32'd0);
    check("t3b_busy", {31'd0, busy}, 32'd1);

    // 4: framing error on the second data byte.
    do_reset("rst4");
    base = n_strobe;
    send_hdr(32'd4);
    send_byte(8'h13, 1'b1);
    send_byte(8'h55, 1'b0);
    wait_cyc(5);
    check("t4_count", n_strobe - base, 32'd1);
    check_strobe("t4_s0", base, 32'd0, 32'h13);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t4_done", {31'd0, done}, 32'd0);

    // 5: one-cycle glitch while idle, then a normal 2-byte image.
    do_reset("rst5");
    base = n_bv;
    rx = 1'b0;
    @(posedge clock);
    rx = 1'b1;
    wait_cyc(30);
    check("t5_bv", n_bv - base, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    base = n_strobe;
    send_hdr(32'd2);
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
    wait_cyc(5);
    check("t5_count", n_strobe - base, 32'd2);
    check_strobe("t5_s0", base + 0, 32'd0, 32'hAA);
    check_strobe("t5_s1", base + 1, 32'd1, 32'h55);
    check("t5_done", {31'd0, done}, 32'd1);

    // 6: reset mid-load, then reload from address 0.
    do_reset("rst6");
    base = n_strobe;
    send_hdr(32'd4);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    wait_cyc(3);
    check("t6_partial", n_strobe - base, 32'd2);
    do_reset("rst6_mid");
    base = n_strobe;
    send_hdr(32'd4);
    send_byte(8'hA1, 1'b1); send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1); send_byte(8'hD4, 1'b1);
    wait_cyc(5);
    check("t6_count", n_strobe - base, 32'd4);
    check_strobe("t6_s0", base + 0, 32'd0, 32'hA1);
    check_strobe("t6_s1", base + 1, 32'd1, 32'hB2);
    check_strobe("t6_s2", base + 2, 32'd2, 32'hC3);
    check_strobe("t6_s3", base + 3, 32'd3, 32'hD4);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    check("strobe_while_released", n_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
